// File: rtl/key_debounce.sv
// Debounces 12 piano key inputs and priority-encodes the highest active key into a note code.
// Optional macro KEY_DEBOUNCE_LATCH_EN keeps the last valid note after all keys are released.
module key_debounce #(
  parameter int TICK_DIV = 1000,
  parameter int SAMPLES  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] keys_raw,
  output logic [11:0] keys_db,
  output logic [3:0]  note,
  output logic        note_valid,
  output logic        press
);

  logic [11:0]        sync1;
  logic [11:0]        sync2;
  logic [15:0]        cnt;
  logic               tick;
  logic [SAMPLES-1:0] hist     [12];
  logic [SAMPLES-1:0] hist_new [12];
  logic [11:0]        agree;
  logic [3:0]         enc;
  logic               enc_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keys_raw;
      sync2 <= sync1;
    end
  end

  assign tick = (cnt == 16'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 16'd1;
  end

  // The new sample is included in the agreement test, so a key flips on the
  // same tick that completes a run of SAMPLES identical samples.
  always_comb begin
    for (int i = 0; i < 12; i++) begin
      hist_new[i] = {hist[i][SAMPLES-2:0], sync2[i]};
      agree[i]    = (&hist_new[i]) | ~(|hist_new[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 12; i++) hist[i] <= '0;
      keys_db <= '0;
    end else if (tick) begin
      for (int i = 0; i < 12; i++) begin
        hist[i] <= hist_new[i];
        if (agree[i]) keys_db[i] <= sync2[i];
      end
    end
  end

  // Ascending scan so the highest set key wins.
  always_comb begin
    enc = 4'hF;
    for (int i = 0; i < 12; i++) begin
      if (keys_db[i]) enc = 4'(11 - i);
    end
    enc_valid = |keys_db;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      note       <= 4'hF;
      note_valid <= 1'b0;
      press      <= 1'b0;
    end else begin
      press <= enc_valid && (enc != note);
      if (enc_valid) begin
        note       <= enc;
        note_valid <= 1'b1;
      end else begin
`ifdef KEY_DEBOUNCE_LATCH_EN
        note       <= note;
        note_valid <= note_valid;
`else
        note       <= 4'hF;
        note_valid <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed self-checking bench for key_debounce with TICK_DIV=4, SAMPLES=4.
module tb_key_debounce;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] keys_raw;
  logic [11:0] keys_db;
  logic [3:0]  note;
  logic        note_valid;
  logic        press;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int press_cnt = 0;
  logic [11:0] db_seen;
  int n;

  key_debounce #(.TICK_DIV(4), .SAMPLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .keys_raw   (keys_raw),
    .keys_db    (keys_db),
    .note       (note),
    .note_valid (note_valid),
    .press      (press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one rising edge, then back to the falling edge where inputs change and outputs are read
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int cycles);
    press_cnt = 0;
    db_seen   = '0;
    for (int k = 0; k < cycles; k++) begin
      step();
      if (press === 1'b1) press_cnt++;
      db_seen = db_seen | keys_db;
    end
  endtask

  initial begin
    rst      = 1'b1;
    keys_raw = 12'h000;
    repeat (3) @(negedge clk);
    chk("rst_keys_db", 16'(keys_db), 16'h000);
    chk("rst_note", 16'(note), 16'hF);
    chk("rst_note_valid", 16'(note_valid), 16'd0);
    chk("rst_press", 16'(press), 16'd0);

    // single key: first tick 4 edges after release, four ticks -> edge 16
    rst      = 1'b0;
    keys_raw = 12'h800;
    cyc      = 0;
    repeat (15) step();
    chk("k11_db_before", 16'(keys_db), 16'h000);
    step();
    chk("k11_db_at16", 16'(keys_db), 16'h800);
    chk("k11_note_lag", 16'(note), 16'hF);
    chk("k11_press_lag", 16'(press), 16'd0);
    step();
    chk("k11_note", 16'(note), 16'h0);
    chk("k11_valid", 16'(note_valid), 16'd1);
    chk("k11_press", 16'(press), 16'd1);
    step();
    chk("k11_press_one", 16'(press), 16'd0);

    keys_raw = 12'h000;
    run(20);
    chk("rel_db", 16'(keys_db), 16'h000);
    chk("rel_note", 16'(note), 16'hF);
    chk("rel_valid", 16'(note_valid), 16'd0);
    chk("rel_press_cnt", 16'(press_cnt), 16'd0);

    // 12-cycle pulse can collect at most 3 agreeing samples
    keys_raw = 12'h020;
    run(12);
    chk("glitch_press_a", 16'(press_cnt), 16'd0);
    chk("glitch_db_a", 16'(db_seen), 16'h000);
    keys_raw = 12'h000;
    run(20);
    chk("glitch_press_b", 16'(press_cnt), 16'd0);
    chk("glitch_db_b", 16'(db_seen), 16'h000);
    chk("glitch_note", 16'(note), 16'hF);

    keys_raw = 12'h801;
    run(20);
    chk("two_db", 16'(keys_db), 16'h801);
    chk("two_note", 16'(note), 16'h0);
    chk("two_press_cnt", 16'(press_cnt), 16'd1);

    keys_raw = 12'h001;
    run(20);
    chk("k0_db", 16'(keys_db), 16'h001);
    chk("k0_note", 16'(note), 16'hB);
    chk("k0_valid", 16'(note_valid), 16'd1);
    chk("k0_press_cnt", 16'(press_cnt), 16'd1);

    keys_raw = 12'h000;
    run(20);
    chk("all_rel_db", 16'(keys_db), 16'h000);
    chk("all_rel_press_cnt", 16'(press_cnt), 16'd0);
`ifdef KEY_DEBOUNCE_LATCH_EN
    chk("all_rel_note", 16'(note), 16'hB);
    chk("all_rel_valid", 16'(note_valid), 16'd1);
`else
    chk("all_rel_note", 16'(note), 16'hF);
    chk("all_rel_valid", 16'(note_valid), 16'd0);
`endif

    keys_raw = 12'h040;
    run(20);
    chk("k6_db", 16'(keys_db), 16'h040);
    chk("k6_note", 16'(note), 16'h5);
    chk("k6_press_cnt", 16'(press_cnt), 16'd1);

    // lower-priority key joins: note unchanged, no press
    keys_raw = 12'h041;
    run(20);
    chk("low_db", 16'(keys_db), 16'h041);
    chk("low_note", 16'(note), 16'h5);
    chk("low_press_cnt", 16'(press_cnt), 16'd0);

    keys_raw = 12'h800;
    run(20);
    chk("pre_rst_db", 16'(keys_db), 16'h800);
    chk("pre_rst_note", 16'(note), 16'h0);
    chk("pre_rst_press_cnt", 16'(press_cnt), 16'd1);

    // prescaler count equals cyc mod 4 since the last reset release
    for (int k = 0; k < 4; k++) begin
      if ((cyc % 4) != 2) step();
    end
    rst = 1'b1;
    step();
    chk("midrst_db", 16'(keys_db), 16'h000);
    chk("midrst_note", 16'(note), 16'hF);
    chk("midrst_valid", 16'(note_valid), 16'd0);
    chk("midrst_press", 16'(press), 16'd0);
    rst = 1'b0;
    cyc = 0;
    n = 0;
    while (keys_db !== 12'h800 && n < 40) begin
      step();
      n++;
    end
    chk("midrst_latency", 16'(n), 16'd16);
    step();
    chk("midrst_note_back", 16'(note), 16'h0);
    chk("midrst_press_back", 16'(press), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
